// File: rtl/crubits_n.sv
// CRU-addressed bit register for a TI-99 style bus, with optional self-clearing pulse bits.
// Define CRUBITS_READBACK_EN to drive ti_cru_in from the addressed bit; otherwise it is tied low.
module crubits_n #(
   parameter int               NBITS        = 8,
   parameter int               SYNC_STAGES  = 2,
   parameter logic [NBITS-1:0] PULSE_MASK   = '0,
   parameter int               PULSE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [0:3]       cru_base,
   input  logic             ti_cru_clk,
   input  logic             ti_memen,
   input  logic [0:14]      addr,
   input  logic             ti_cru_out,
   output logic             ti_cru_in,
   output logic [0:NBITS-1] bits,
   output logic             bits_wr
);

   localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYCLES);

   typedef enum logic {IDLE, STROBE} state_t;

   logic [6:0]             idx;
   logic                   sel;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES:0]   vld_pipe_q;
   logic                   edge_q, fall_q, rise_q;
   state_t                 state_q;
   logic                   cap_sel_q, cap_dat_q;
   logic [6:0]             cap_idx_q;
   logic [0:NBITS-1]       bits_q;
   logic                   bits_wr_q;
   logic [7:0]             cnt_q [NBITS];

   assign idx = addr[8:14];
   assign sel = (addr[0:3] == 4'b0001) && (addr[4:7] == cru_base) && (32'(idx) < NBITS);

   // Edges only count once the chain and edge flop hold real samples, so the
   // all-ones reset value can never masquerade as a falling edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q     <= '1;
         vld_pipe_q <= '0;
         edge_q     <= 1'b1;
         fall_q     <= 1'b0;
         rise_q     <= 1'b0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], ti_cru_clk};
         vld_pipe_q <= {vld_pipe_q[SYNC_STAGES-1:0], 1'b1};
         edge_q     <= sync_q[SYNC_STAGES-1];
         fall_q     <= vld_pipe_q[SYNC_STAGES] &  edge_q & ~sync_q[SYNC_STAGES-1];
         rise_q     <= vld_pipe_q[SYNC_STAGES] & ~edge_q &  sync_q[SYNC_STAGES-1];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         cap_sel_q <= 1'b0;
         cap_idx_q <= '0;
         cap_dat_q <= 1'b0;
         bits_q    <= '0;
         bits_wr_q <= 1'b0;
         for (int i = 0; i < NBITS; i++) cnt_q[i] <= '0;
      end else begin
         bits_wr_q <= 1'b0;
         for (int i = 0; i < NBITS; i++) begin
            if (PULSE_MASK[i] && cnt_q[i] != 8'd0) begin
               cnt_q[i] <= cnt_q[i] - 8'd1;
               if (cnt_q[i] == 8'd1) bits_q[i] <= 1'b0;
            end
         end
         // A committed write lands after the expiry logic, so it wins the same cycle.
         case (state_q)
            IDLE: if (fall_q) begin
               state_q   <= STROBE;
               cap_sel_q <= sel & ti_memen;
               cap_idx_q <= idx;
               cap_dat_q <= ti_cru_out;
            end
            STROBE: if (rise_q) begin
               state_q <= IDLE;
               if (cap_sel_q) begin
                  bits_wr_q <= 1'b1;
                  for (int i = 0; i < NBITS; i++) begin
                     if (cap_idx_q == 7'(i)) begin
                        bits_q[i] <= cap_dat_q;
                        if (PULSE_MASK[i]) cnt_q[i] <= cap_dat_q ? PULSE_LOAD : 8'd0;
                     end
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bits    = bits_q;
   assign bits_wr = bits_wr_q;

`ifdef CRUBITS_READBACK_EN
   logic rb_bit;
   always_comb begin
      rb_bit = 1'b0;
      for (int i = 0; i < NBITS; i++)
         if (idx == 7'(i)) rb_bit = bits_q[i];
   end
   assign ti_cru_in = sel & ti_memen & rb_bit;
`else
   assign ti_cru_in = 1'b0;
`endif

endmodule

// File: tb/tb_crubits_n.sv
// Randomized bench for crubits_n: stimulus queues expected writes, a monitor
// replays them into a cycle-level bit/expiry model and compares every cycle.
module tb_crubits_n;
   localparam int         NB = 8;
   localparam int         SS = 2;
   localparam int         PC = 16;
   localparam logic [7:0] PM = 8'h41;

   logic        clk = 1'b0, reset_n = 1'b0;
   logic [0:3]  cru_base = 4'h2;
   logic        ti_cru_clk = 1'b1, ti_memen = 1'b1, ti_cru_out = 1'b0;
   logic [0:14] addr = '0;
   logic        ti_cru_in, bits_wr;
   logic [0:7]  bits;

   crubits_n #(.NBITS(NB), .SYNC_STAGES(SS), .PULSE_MASK(PM), .PULSE_CYCLES(PC)) dut (
      .clk(clk), .reset_n(reset_n), .cru_base(cru_base), .ti_cru_clk(ti_cru_clk),
      .ti_memen(ti_memen), .addr(addr), .ti_cru_out(ti_cru_out), .ti_cru_in(ti_cru_in),
      .bits(bits), .bits_wr(bits_wr));

   always #5 clk = ~clk;

   int errs = 0, checks = 0, cyc = 0, last_wr_cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int idx; logic dat; } wr_t;
   wr_t        exp_q[$];
   logic [0:7] mbits = '0;
   int         exp_t[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: a write takes effect on the bits_wr cycle; a pulse bit written 1
   // drops exactly PC cycles later unless rewritten.
   always @(posedge clk) begin
      wr_t w;
      #1;
      if (!reset_n) begin
         mbits = '0;
         for (int i = 0; i < 8; i++) exp_t[i] = 0;
         exp_q.delete();
         chk("reset bits", bits, 0);
         chk("reset bits_wr", bits_wr, 0);
      end else begin
         for (int i = 0; i < 8; i++)
            if (exp_t[i] != 0 && exp_t[i] == cyc) begin mbits[i] = 1'b0; exp_t[i] = 0; end
         if (bits_wr) begin
            if (exp_q.size() == 0) chk("unexpected bits_wr", bits_wr, 0);
            else begin
               w = exp_q.pop_front();
               mbits[w.idx] = w.dat;
               if (PM[w.idx]) exp_t[w.idx] = w.dat ? cyc + PC : 0;
            end
         end
         chk("bits model", bits, mbits);
      end
   end

   task automatic cru_write(input logic [0:3] hi, input logic [0:3] base, input int idx,
                            input logic memen, input logic dat, input int low);
      logic exp_wr;
      int   n;
      exp_wr = (hi == 4'b0001) && (base == cru_base) && memen && (idx < NB);
      @(negedge clk);
      addr = {hi, base, 7'(idx)}; ti_memen = memen; ti_cru_out = dat; ti_cru_clk = 1'b0;
      repeat (low) @(negedge clk);
      if (exp_wr) exp_q.push_back(wr_t'{idx, dat});
      ti_cru_clk = 1'b1;
      if (exp_wr) begin
         n = 0;
         do begin @(posedge clk); n++; #1; end while (!bits_wr && n < 12);
         chk("write latency", n, SS + 2);
         last_wr_cyc = cyc;
      end else repeat (SS + 6) @(negedge clk);
   endtask

   initial begin
      int         w;
      logic [0:7] pat;
      logic [0:3] hi, base;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);

      cru_write(4'b0001, 4'h2, 3, 1'b1, 1'b1, 3);
      chk("bit3 write", bits, 8'b0001_0000);
      @(posedge clk); #1;
      chk("bits_wr one cycle", bits_wr, 0);

      cru_write(4'b0001, 4'h3, 3, 1'b1, 1'b0, 3);
      chk("wrong base ignored", bits, 8'b0001_0000);
      cru_write(4'b0001, 4'h2, 3, 1'b0, 1'b0, 3);
      chk("memen low ignored", bits, 8'b0001_0000);
      cru_write(4'b0001, 4'h2, 8, 1'b1, 1'b1, 3);
      chk("idx 8 ignored", bits, 8'b0001_0000);

      cru_write(4'b0001, 4'h2, 0, 1'b1, 1'b1, 2);
      w = last_wr_cyc;
      do begin @(posedge clk); #1; end while (bits[0] && cyc - w < 40);
      chk("pulse duration", cyc - w, PC);

      cru_write(4'b0001, 4'h2, 0, 1'b1, 1'b1, 2);
      cru_write(4'b0001, 4'h2, 0, 1'b1, 1'b1, 1);
      w = last_wr_cyc;
      do begin @(posedge clk); #1; end while (bits[0] && cyc - w < 40);
      chk("pulse reload", cyc - w, PC);

      cru_write(4'b0001, 4'h2, 0, 1'b1, 1'b1, 2);
      cru_write(4'b0001, 4'h2, 0, 1'b1, 1'b0, 1);
      chk("pulse write0 clears", bits[0], 0);
      repeat (20) @(negedge clk);

      cru_write(4'b0001, 4'h2, 6, 1'b1, 1'b1, 2);
      cru_write(4'b0001, 4'h2, 0, 1'b1, 1'b1, 2);
      repeat (25) @(negedge clk);

      // Reset arrives while a valid strobe is held low.
      @(negedge clk);
      addr = {4'b0001, 4'h2, 7'd5}; ti_memen = 1'b1; ti_cru_out = 1'b1; ti_cru_clk = 1'b0;
      repeat (5) @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("async reset bits", bits, 0);
      chk("async reset bits_wr", bits_wr, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      ti_cru_clk = 1'b1;
      repeat (10) @(negedge clk);
      chk("no write after reset", bits, 0);
      cru_write(4'b0001, 4'h2, 5, 1'b1, 1'b1, 3);
      chk("write after reset", bits, 8'b0000_0100);

      repeat (40) begin
         hi   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0001;
         base = ($urandom_range(0, 5) == 0) ? 4'h3 : 4'h2;
         cru_write(hi, base, $urandom_range(0, 9), $urandom_range(0, 5) != 0,
                   1'($urandom), $urandom_range(1, 4));
      end
      repeat (20) @(negedge clk);

      pat = 8'hA5;
      for (int i = 7; i >= 0; i--) cru_write(4'b0001, 4'h2, i, 1'b1, pat[i], 2);
      chk("pattern A5", bits, pat);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         addr = {4'b0001, 4'h2, 7'(i)}; ti_memen = 1'b1;
         #1;
`ifdef CRUBITS_READBACK_EN
         chk("readback", ti_cru_in, pat[i]);
`else
         chk("readback tied low", ti_cru_in, 0);
`endif
      end
      ti_memen = 1'b0;
      #1;
      chk("readback memen low", ti_cru_in, 0);

      repeat (5) @(negedge clk);
      chk("queue drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
endmodule
